// File: rtl/instr_fetch_unit.sv
// Fetch stage: issues one word fetch per PC over a valid/ready port,
// returns the instruction with a one-cycle strobe and reports fetch faults.
module instr_fetch_unit #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int TIMEOUT = 255,
    parameter logic [DATA_W-1:0] NOP_INSTR = 'h00000013
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc,
    input  logic              fetch_req,
    input  logic              flush,
    output logic              pc_stall,
    output logic [DATA_W-1:0] instr,
    output logic              instr_valid,
    output logic              fetch_fault,
    output logic [1:0]        fault_cause,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [DATA_W-1:0] imem_rsp_data,
    input  logic              imem_rsp_err
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE,
        S_FAULT
    } state_e;

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  instr_q, instr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               drop_q, drop_d;
    logic [1:0]         cause_q, cause_d;

    logic misaligned;
    logic drop_now;

    assign misaligned = |pc[1:0];
    assign drop_now   = drop_q | flush;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            instr_q <= NOP_INSTR;
            cnt_q   <= '0;
            drop_q  <= 1'b0;
            cause_q <= 2'b00;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            instr_q <= instr_d;
            cnt_q   <= cnt_d;
            drop_q  <= drop_d;
            cause_q <= cause_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        instr_d = instr_q;
        cnt_d   = cnt_q;
        drop_d  = drop_q;
        cause_d = cause_q;
        unique case (state_q)
            S_IDLE: begin
                if (fetch_req && !flush) begin
                    if (misaligned) begin
                        state_d = S_FAULT;
                        cause_d = 2'b11;
                    end else begin
                        addr_d  = pc;
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                if (imem_req_ready) begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                    drop_d  = flush;
                end else if (flush) begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (imem_rsp_valid) begin
                    if (drop_now) begin
                        state_d = S_IDLE;
                        drop_d  = 1'b0;
                    end else if (imem_rsp_err) begin
                        state_d = S_FAULT;
                        cause_d = 2'b01;
                    end else begin
                        instr_d = imem_rsp_data;
                        state_d = S_DONE;
                    end
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    drop_d = 1'b0;
                    if (drop_now) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_FAULT;
                        cause_d = 2'b10;
                    end
                end else if (flush) begin
                    drop_d = 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_FAULT: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Strobes are gated by reset so a mid-fetch reset withdraws them at once.
    assign pc_stall = rst &
        (((state_q == S_IDLE) & fetch_req & ~flush & ~misaligned) |
         (state_q == S_REQ) | (state_q == S_WAIT));

    assign imem_req_valid = rst & (state_q == S_REQ);
    assign imem_req_addr  = addr_q;
    assign instr          = instr_q;
    assign instr_valid    = rst & (state_q == S_DONE) & ~flush;
    assign fetch_fault    = rst & (state_q == S_FAULT);
    assign fault_cause    = fetch_fault ? cause_q : 2'b00;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed, table-driven bench for instr_fetch_unit (TIMEOUT=8).
module tb_instr_fetch_unit;

    logic        clk;
    logic        rst;
    logic [31:0] pc;
    logic        fetch_req;
    logic        flush;
    logic        pc_stall;
    logic [31:0] instr;
    logic        instr_valid;
    logic        fetch_fault;
    logic [1:0]  fault_cause;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        imem_rsp_err;

    int errors = 0;
    int checks = 0;

    instr_fetch_unit #(
        .ADDR_W(32), .DATA_W(32), .TIMEOUT(8), .NOP_INSTR(32'h00000013)
    ) dut (
        .clk(clk), .rst(rst), .pc(pc), .fetch_req(fetch_req),
        .flush(flush), .pc_stall(pc_stall), .instr(instr),
        .instr_valid(instr_valid), .fetch_fault(fetch_fault),
        .fault_cause(fault_cause), .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .imem_rsp_err(imem_rsp_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        rst;
        logic        freq;
        logic        flush;
        logic [31:0] pc;
        logic        rdy;
        logic        rv;
        logic [31:0] rdata;
        logic        rerr;
        logic        e_stall;
        logic        e_reqv;
        logic [31:0] e_addr;
        logic [31:0] e_instr;
        logic        e_iv;
        logic        e_ff;
        logic [1:0]  e_cause;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t mk(
        logic r, logic fq, logic fl, logic [31:0] p, logic rd,
        logic v, logic [31:0] d, logic er,
        logic es, logic erv, logic [31:0] ea, logic [31:0] ei,
        logic eiv, logic eff, logic [1:0] ec);
        vec_t t;
        t.rst = r; t.freq = fq; t.flush = fl; t.pc = p; t.rdy = rd;
        t.rv = v; t.rdata = d; t.rerr = er;
        t.e_stall = es; t.e_reqv = erv; t.e_addr = ea; t.e_instr = ei;
        t.e_iv = eiv; t.e_ff = eff; t.e_cause = ec;
        return t;
    endfunction

    task automatic chk(input string nm, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %h expected %h",
                     nm, idx, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t t, input int idx);
        rst = t.rst; fetch_req = t.freq; flush = t.flush; pc = t.pc;
        imem_req_ready = t.rdy; imem_rsp_valid = t.rv;
        imem_rsp_data = t.rdata; imem_rsp_err = t.rerr;
        #3;
        chk("pc_stall", idx, {31'b0, pc_stall}, {31'b0, t.e_stall});
        chk("req_valid", idx, {31'b0, imem_req_valid}, {31'b0, t.e_reqv});
        chk("req_addr", idx, imem_req_addr, t.e_addr);
        chk("instr", idx, instr, t.e_instr);
        chk("instr_valid", idx, {31'b0, instr_valid}, {31'b0, t.e_iv});
        chk("fetch_fault", idx, {31'b0, fetch_fault}, {31'b0, t.e_ff});
        chk("fault_cause", idx, {30'b0, fault_cause}, {30'b0, t.e_cause});
        @(posedge clk);
        #1;
    endtask

    localparam logic [31:0] NOP = 32'h00000013;
    localparam logic [31:0] I1  = 32'h00500093;
    localparam logic [31:0] I2  = 32'h00A00113;
    localparam logic [31:0] I3  = 32'h00000517;

    initial begin
        rst = 1'b0; fetch_req = 1'b1; flush = 1'b0; pc = 32'h100;
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0;
        imem_rsp_data = '0; imem_rsp_err = 1'b0;
        #2;
        chk("rst_pc_stall", -1, {31'b0, pc_stall}, 32'd0);
        chk("rst_req_valid", -1, {31'b0, imem_req_valid}, 32'd0);
        @(posedge clk);
        #1;

        // reset, then basic fetch of 0x100
        tv.push_back(mk(0,1,0,32'h100,0,0,0,0, 0,0,32'h0,NOP,0,0,0));
        tv.push_back(mk(1,1,0,32'h100,0,0,0,0, 1,0,32'h0,NOP,0,0,0));
        tv.push_back(mk(1,0,0,32'h100,1,0,0,0, 1,1,32'h100,NOP,0,0,0));
        tv.push_back(mk(1,0,0,32'h100,0,0,0,0, 1,0,32'h100,NOP,0,0,0));
        tv.push_back(mk(1,0,0,32'h100,0,1,I1,0, 1,0,32'h100,NOP,0,0,0));
        tv.push_back(mk(1,0,0,32'h100,0,0,0,0, 0,0,32'h100,I1,1,0,0));
        tv.push_back(mk(1,0,0,32'h100,0,0,0,0, 0,0,32'h100,I1,0,0,0));
        // misaligned pc
        tv.push_back(mk(1,1,0,32'h102,0,0,0,0, 0,0,32'h100,I1,0,0,0));
        tv.push_back(mk(1,0,0,32'h102,0,0,0,0, 0,0,32'h100,I1,0,1,3));
        tv.push_back(mk(1,0,0,32'h102,0,0,0,0, 0,0,32'h100,I1,0,0,0));
        // backpressure, pc changes while request is held
        tv.push_back(mk(1,1,0,32'h100,0,0,0,0, 1,0,32'h100,I1,0,0,0));
        tv.push_back(mk(1,0,0,32'h200,0,0,0,0, 1,1,32'h100,I1,0,0,0));
        tv.push_back(mk(1,0,0,32'h200,0,0,0,0, 1,1,32'h100,I1,0,0,0));
        tv.push_back(mk(1,0,0,32'h200,0,0,0,0, 1,1,32'h100,I1,0,0,0));
        tv.push_back(mk(1,0,0,32'h200,1,0,0,0, 1,1,32'h100,I1,0,0,0));
        // flush in WAIT drops the late response
        tv.push_back(mk(1,0,1,32'h200,0,0,0,0, 1,0,32'h100,I1,0,0,0));
        tv.push_back(mk(1,0,0,32'h200,0,0,0,0, 1,0,32'h100,I1,0,0,0));
        tv.push_back(mk(1,0,0,32'h200,0,1,32'hDEADBEEF,0,
                        1,0,32'h100,I1,0,0,0));
        tv.push_back(mk(1,0,0,32'h200,0,0,0,0, 0,0,32'h100,I1,0,0,0));
        // flush in DONE masks the strobe
        tv.push_back(mk(1,1,0,32'h300,0,0,0,0, 1,0,32'h100,I1,0,0,0));
        tv.push_back(mk(1,0,0,32'h300,1,0,0,0, 1,1,32'h300,I1,0,0,0));
        tv.push_back(mk(1,0,0,32'h300,0,1,I2,0, 1,0,32'h300,I1,0,0,0));
        tv.push_back(mk(1,0,1,32'h300,0,0,0,0, 0,0,32'h300,I2,0,0,0));
        tv.push_back(mk(1,0,0,32'h300,0,0,0,0, 0,0,32'h300,I2,0,0,0));
        // flush in REQ without accept withdraws the request
        tv.push_back(mk(1,1,0,32'h400,0,0,0,0, 1,0,32'h300,I2,0,0,0));
        tv.push_back(mk(1,0,1,32'h400,0,0,0,0, 1,1,32'h400,I2,0,0,0));
        tv.push_back(mk(1,0,0,32'h400,0,0,0,0, 0,0,32'h400,I2,0,0,0));
        // response coincident with accept is ignored
        tv.push_back(mk(1,1,0,32'h500,0,0,0,0, 1,0,32'h400,I2,0,0,0));
        tv.push_back(mk(1,0,0,32'h500,1,1,32'h11111111,0,
                        1,1,32'h500,I2,0,0,0));
        tv.push_back(mk(1,0,0,32'h500,0,0,0,0, 1,0,32'h500,I2,0,0,0));
        tv.push_back(mk(1,0,0,32'h500,0,1,I3,0, 1,0,32'h500,I2,0,0,0));
        tv.push_back(mk(1,0,0,32'h500,0,0,0,0, 0,0,32'h500,I3,1,0,0));
        // flush together with accept drops the response
        tv.push_back(mk(1,1,0,32'h600,0,0,0,0, 1,0,32'h500,I3,0,0,0));
        tv.push_back(mk(1,0,1,32'h600,1,0,0,0, 1,1,32'h600,I3,0,0,0));
        tv.push_back(mk(1,0,0,32'h600,0,1,32'h22222222,0,
                        1,0,32'h600,I3,0,0,0));
        tv.push_back(mk(1,0,0,32'h600,0,0,0,0, 0,0,32'h600,I3,0,0,0));

        for (int i = 0; i < tv.size(); i++) run_vec(tv[i], i);

        // timeout: eight WAIT cycles with no response, then fault 10
        run_vec(mk(1,1,0,32'h700,0,0,0,0, 1,0,32'h600,I3,0,0,0), 100);
        run_vec(mk(1,0,0,32'h700,1,0,0,0, 1,1,32'h700,I3,0,0,0), 101);
        for (int k = 0; k < 8; k++)
            run_vec(mk(1,0,0,32'h700,0,0,0,0,
                       1,0,32'h700,I3,0,0,0), 110 + k);
        run_vec(mk(1,0,0,32'h700,0,0,0,0, 0,0,32'h700,I3,0,1,2), 120);
        run_vec(mk(1,0,0,32'h700,0,0,0,0, 0,0,32'h700,I3,0,0,0), 121);

        // bus error response
        run_vec(mk(1,1,0,32'h800,0,0,0,0, 1,0,32'h700,I3,0,0,0), 130);
        run_vec(mk(1,0,0,32'h800,1,0,0,0, 1,1,32'h800,I3,0,0,0), 131);
        run_vec(mk(1,0,0,32'h800,0,1,32'h33333333,1,
                   1,0,32'h800,I3,0,0,0), 132);
        run_vec(mk(1,0,0,32'h800,0,0,0,0, 0,0,32'h800,I3,0,1,1), 133);
        run_vec(mk(1,0,0,32'h800,0,0,0,0, 0,0,32'h800,I3,0,0,0), 134);

        // reset in the middle of a fetch
        run_vec(mk(1,1,0,32'h900,0,0,0,0, 1,0,32'h800,I3,0,0,0), 140);
        run_vec(mk(0,0,0,32'h900,0,0,0,0, 0,0,32'h900,I3,0,0,0), 141);
        run_vec(mk(1,0,0,32'h900,0,0,0,0, 0,0,32'h0,NOP,0,0,0), 142);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: time limit reached, expected finish");
        $fatal(1);
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Fetch stage that sits directly downstream of the program-counter register. It consumes the current PC and issues a word fetch over a valid/ready instruction-memory port. It returns the instruction to decode with a one-cycle valid strobe. It drives pc_stall so the PC register holds while a fetch is outstanding. It also reports misalignment, bus-error and timeout faults.

Parameters:
ADDR_W, 32, width of PC and memory address
DATA_W, 32, instruction width
TIMEOUT, 255, max cycles in WAIT before timeout fault (counter width = clog2(TIMEOUT+1))
NOP_INSTR, 32'h00000013, reset/default value of instr (addi x0,x0,0)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  reset, synchronous, active-low
pc  in  ADDR_W  current PC from PC register
fetch_req  in  1  core requests instruction at pc
flush  in  1  redirect; discard any in-flight fetch
pc_stall  out  1  PC register must hold its value
instr  out  DATA_W  fetched instruction (registered)
instr_valid  out  1  one-cycle strobe, instr valid
fetch_fault  out  1  one-cycle fault strobe
fault_cause  out  2  01 bus error, 10 timeout, 11 misaligned; 00 when fetch_fault=0
imem_req_valid  out  1  memory request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  ADDR_W  word address (latched pc)
imem_rsp_valid  in  1  memory response valid
imem_rsp_data  in  DATA_W  response data
imem_rsp_err  in  1  response carries bus error

Behaviour:
- Reset (rst=0 at posedge): state=IDLE, instr=NOP_INSTR, addr_q=0, timeout count=0, drop=0. All 1-bit outputs 0, imem_req_addr=0, fault_cause=0.
- States: IDLE, REQ, WAIT, DONE, FAULT.
- IDLE:
  - fetch_req=1, flush=0, pc[1:0]!=0 -> FAULT with cause 11; no memory request is issued.
  - fetch_req=1, flush=0, pc aligned -> addr_q<=pc, go to REQ.
  - flush=1 -> remain in IDLE.
- REQ: imem_req_valid=1, imem_req_addr=addr_q. Addr is stable until accepted.
  - Accept (valid&ready) -> WAIT, count<=0.
  - Accept with flush=1 in the same cycle -> WAIT with drop<=1.
  - flush=1 without accept -> IDLE, request withdrawn.
- WAIT: count increments each cycle. Responses are sampled only in WAIT; responses in any other state are ignored. At most one request is outstanding.
  - rsp_valid with drop=1 (set earlier or by flush this cycle) -> IDLE, no strobe, drop<=0.
  - rsp_valid with rsp_err=1 -> FAULT, cause 01.
  - rsp_valid with rsp_err=0 -> instr<=rsp_data, go to DONE.
  - No rsp_valid and count==TIMEOUT-1 -> FAULT cause 10, or IDLE if drop=1.
- DONE: instr_valid = !flush for exactly this cycle, pc_stall=0 so the PC advances. Next state is IDLE. instr holds its value until the next successful fetch.
- FAULT: fetch_fault=1 and fault_cause valid for exactly this cycle, pc_stall=0. Next state is IDLE. instr is unchanged.
- pc_stall = (IDLE & fetch_req & !flush & pc aligned) | REQ | WAIT.
  - Combinational from state and inputs.
  - Deasserted on a misaligned request so the trap path can redirect.
- Minimum latency: fetch_req at cycle 0, REQ at cycle 1 (ready=1), WAIT at cycle 2 with response, instr_valid at cycle 3.
- A response arriving in the same cycle as request acceptance is not sampled; memory latency is at least 1 cycle.
- rst=0 mid-fetch aborts immediately to the reset state. The memory port must tolerate the dropped request.

Test Plan:
1. Hold rst=0 for 2 cycles with fetch_req=1 -> pc_stall=0, imem_req_valid=0, instr=0x00000013, fault_cause=0; release -> first fetch starts next cycle.
2. pc=0x100, ready=1, rsp 2 cycles after accept with data 0x00500093 -> imem_req_addr=0x100, pc_stall high in IDLE/REQ/WAIT and low in DONE, instr_valid exactly 1 cycle, instr=0x00500093.
3. pc=0x102, fetch_req=1 -> imem_req_valid never asserts, fetch_fault pulses 1 cycle later with fault_cause=11, pc_stall=0.
4. imem_req_ready=0 for 3 cycles, pc changed meanwhile to 0x200 -> imem_req_valid=1 and addr stays 0x100 for all 3 cycles, pc_stall=1, accept on 4th cycle.
5. flush=1 during WAIT, rsp 0xDEADBEEF arrives 2 cycles later -> no instr_valid, instr unchanged, IDLE next; flush in DONE -> instr_valid=0.
6. TIMEOUT=8, no rsp -> fetch_fault with cause 10 after 8 WAIT cycles. Separately, rsp_valid with rsp_err=1 -> fault_cause=01, instr unchanged.
